// File: rtl/svm_pkg.sv
// svm_pkg: shared constants and the sequencer state type for the SVM batch
// controller. Imported by the interface, the label packer and the top.
package svm_pkg;

   localparam int SVM_BEAT_BYTES    = 16;
   localparam int SVM_FEATURES      = 8192;
   localparam int SVM_BEATS_PER_VEC = SVM_FEATURES / SVM_BEAT_BYTES;
   localparam int RES_W             = 32;
   localparam int CNT_W             = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FEED,
      S_WAIT_LBL,
      S_CLEAR,
      S_PUSH,
      S_DONE
   } svm_state_e;

endpackage

// File: rtl/svm_batch_ctrl_if.sv
// svm_batch_ctrl_if: bundles the batch control, upstream FIFO, engine and
// result handshakes of the batch sequencer.
//   master : the sequencer (drives busy/done, src_rd, eng_empty/eng_rst, res_*)
//   slave  : the surroundings (host start, FIFO, engine, result consumer)
interface svm_batch_ctrl_if;
   import svm_pkg::*;

   logic             start;
   logic [CNT_W-1:0] num_vecs;
   logic             busy;
   logic             done;
   logic             src_empty;
   logic             src_rd;
   logic             eng_empty;
   logic             eng_rd;
   logic             eng_label;
   logic             eng_label_ready;
   logic             eng_rst;
   logic [RES_W-1:0] res_data;
   logic             res_valid;
   logic             res_ready;

   modport master (
      input  start, num_vecs, src_empty, eng_rd, eng_label, eng_label_ready, res_ready,
      output busy, done, src_rd, eng_empty, eng_rst, res_data, res_valid
   );

   modport slave (
      output start, num_vecs, src_empty, eng_rd, eng_label, eng_label_ready, res_ready,
      input  busy, done, src_rd, eng_empty, eng_rst, res_data, res_valid
   );

endinterface

// File: rtl/svm_label_packer.sv
// svm_label_packer: collects one label bit per classified vector into a
// RES_W-bit word and holds it under a valid/ready handshake.
//   clk_i, rst_i : clock, async active-high reset
//   cap_i, lbl_i : capture lbl_i at bit position idx (idx then advances)
//   load_i       : raise valid with the word collected so far
//   ready_i      : consumer ready; valid&ready clears word, index and valid
//   data_o/valid_o, full_o (RES_W labels held), accept_o (handshake fired)
module svm_label_packer
   import svm_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cap_i,
   input  logic             lbl_i,
   input  logic             load_i,
   input  logic             ready_i,
   output logic [RES_W-1:0] data_o,
   output logic             valid_o,
   output logic             full_o,
   output logic             accept_o
);

   localparam int IDX_W = $clog2(RES_W + 1);

   logic [RES_W-1:0] shift_q, shift_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             valid_q, valid_d;

   assign accept_o = valid_q & ready_i;
   assign full_o   = (idx_q == IDX_W'(RES_W));
   assign data_o   = shift_q;
   assign valid_o  = valid_q;

   always_comb begin
      shift_d = shift_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      if (accept_o) begin
         // unused upper bits of the next word start at zero
         shift_d = '0;
         idx_d   = '0;
         valid_d = 1'b0;
      end else begin
         if (load_i) valid_d = 1'b1;
         // the controller never captures once full, so the low bits index safely
         if (cap_i) begin
            shift_d[idx_q[IDX_W-2:0]] = lbl_i;
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shift_q <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         shift_q <= shift_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/svm_batch_ctrl.sv
// svm_batch_ctrl: meters exactly BEATS_PER_VEC upstream FIFO beats into the
// SVM engine per vector, captures each label, resets the engine between
// vectors and pushes packed label words to the result consumer.
//   clk, reset : clock, async active-high reset (aborts any batch)
//   bus        : start/num_vecs/busy/done, src_empty/src_rd,
//                eng_empty/eng_rd/eng_label/eng_label_ready/eng_rst,
//                res_data/res_valid/res_ready
module svm_batch_ctrl
   import svm_pkg::*;
#(
   parameter int BEATS_PER_VEC = SVM_BEATS_PER_VEC
) (
   input  logic               clk,
   input  logic               reset,
   svm_batch_ctrl_if.master   bus
);

   localparam int                BEAT_W    = $clog2(BEATS_PER_VEC + 1);
   localparam logic [BEAT_W-1:0] BEAT_FULL = BEAT_W'(BEATS_PER_VEC);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS_PER_VEC - 1);

   svm_state_e       state_q, state_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [CNT_W-1:0] vec_q, vec_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic             lrdy_q;
   logic             eng_rst_q;
   logic             done_q;

   logic src_rd, eng_empty, cap, load, full, accept, lbl_rise;

   // label_ready is sticky, so only its rising edge marks a fresh label
   assign lbl_rise = bus.eng_label_ready & ~lrdy_q;

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      vec_d     = vec_q;
      num_d     = num_q;
      src_rd    = 1'b0;
      eng_empty = 1'b1;
      cap       = 1'b0;
      load      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               num_d   = bus.num_vecs;
               vec_d   = '0;
               beat_d  = '0;
               state_d = (bus.num_vecs == '0) ? S_DONE : S_FEED;
            end
         end
         S_FEED: begin
            // engine only sees data while the vector still needs beats
            eng_empty = bus.src_empty | (beat_q == BEAT_FULL);
            src_rd    = bus.eng_rd & ~bus.src_empty & (beat_q < BEAT_FULL);
            if (src_rd) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == BEAT_LAST) state_d = S_WAIT_LBL;
            end
         end
         S_WAIT_LBL: begin
            if (lbl_rise) begin
               cap     = 1'b1;
               vec_d   = vec_q + 1'b1;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            beat_d = '0;
            if (full || vec_q == num_q) begin
               load    = 1'b1;
               state_d = S_PUSH;
            end else begin
               state_d = S_FEED;
            end
         end
         S_PUSH: begin
            if (accept) state_d = (vec_q == num_q) ? S_DONE : S_FEED;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         beat_q    <= '0;
         vec_q     <= '0;
         num_q     <= '0;
         lrdy_q    <= 1'b0;
         eng_rst_q <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         vec_q     <= vec_d;
         num_q     <= num_d;
         lrdy_q    <= bus.eng_label_ready;
         // registered so eng_rst is high exactly while in CLEAR
         eng_rst_q <= (state_d == S_CLEAR);
         done_q    <= (state_q == S_DONE);
      end
   end

   svm_label_packer u_packer (
      .clk_i    (clk),
      .rst_i    (reset),
      .cap_i    (cap),
      .lbl_i    (bus.eng_label),
      .load_i   (load),
      .ready_i  (bus.res_ready),
      .data_o   (bus.res_data),
      .valid_o  (bus.res_valid),
      .full_o   (full),
      .accept_o (accept)
   );

   assign bus.src_rd    = src_rd;
   assign bus.eng_empty = eng_empty;
   assign bus.eng_rst   = eng_rst_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = done_q;

endmodule

// File: tb/tb_svm_batch_ctrl.sv
// Bench for svm_batch_ctrl: random FIFO/engine/consumer behaviour, label
// words predicted from the per-batch label list and checked by a monitor.
module tb_svm_batch_ctrl;
   import svm_pkg::*;

   localparam int BPV = SVM_BEATS_PER_VEC;

   logic clk = 1'b0;
   logic reset = 1'b0;

   svm_batch_ctrl_if bus();

   svm_batch_ctrl #(.BEATS_PER_VEC(BPV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0, cyc = 0;
   int lbl_q[$];
   logic [31:0] exp_q[$];
   bit done_pend = 0, done_seen = 0, chk_lat = 0;
   int exp_n = 0, batch_rd = 0, vec_done = 0, start_cyc = 0;
   int eng_beats = 0, lbl_dly = 0, bp_left = 0;
   bit lbl_up = 0, eng_clr = 0, starve = 0, spur = 0, held_v = 0;
   logic [31:0] held;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string name);
      chk(name, {bus.src_rd, bus.eng_empty, bus.eng_rst, bus.busy, bus.done, bus.res_valid, bus.res_data},
          {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // environment: upstream FIFO, engine, result consumer
   always begin
      @(posedge clk); #1;
      bus.src_empty = starve ? ($urandom_range(2) == 0) : 1'b0;
      bus.eng_rd    = ($urandom_range(9) != 0);
      if (reset) begin
         bus.eng_label_ready = 1'b0;
         bus.res_ready       = 1'b0;
      end else begin
         if (eng_clr) begin
            bus.eng_label_ready = 1'b0;
            eng_clr = 0;
         end else if (lbl_up) begin
            bus.eng_label_ready = 1'b1;
         end else if (eng_beats == BPV) begin
            if (lbl_dly > 0) lbl_dly--;
            else begin
               bus.eng_label       = (lbl_q.size() != 0) ? lbl_q.pop_front() : 1'b0;
               bus.eng_label_ready = 1'b1;
               lbl_up = 1;
            end
         end else begin
            // spurious label_ready blips mid-vector must be ignored
            bus.eng_label       = $urandom_range(1);
            bus.eng_label_ready = spur && eng_beats > 10 && eng_beats < 500 && ($urandom_range(15) == 0);
         end
         if (bus.res_valid && bp_left > 0) begin
            bp_left--;
            bus.res_ready = 1'b0;
         end else begin
            bus.res_ready = $urandom_range(1);
         end
      end
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.src_rd) begin
            chk("rd_gated", {bus.src_empty, bus.res_valid, eng_beats >= BPV}, 3'b000);
            eng_beats++;
            batch_rd++;
         end
         if (bus.eng_rst && lbl_up) begin
            chk("beats_per_vec", eng_beats, BPV);
            eng_beats = 0;
            lbl_up    = 0;
            eng_clr   = 1;
            lbl_dly   = $urandom_range(3);
            vec_done++;
         end
         if (bus.res_valid) begin
            if (!held_v) begin
               held   = bus.res_data;
               held_v = 1;
            end
            if (bus.res_ready) begin
               chk("word_stable", bus.res_data, held);
               chk("word_pending", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) chk("res_data", bus.res_data, exp_q.pop_front());
               held_v = 0;
            end
         end
         if (bus.done) begin
            chk("done_expected", done_pend, 1);
            chk("words_left", exp_q.size(), 0);
            chk("batch_rd", batch_rd, exp_n * BPV);
            chk("vec_count", vec_done, exp_n);
            if (chk_lat) chk("done_latency", cyc - start_cyc, 2);
            done_pend = 0;
            done_seen = 1;
         end
      end
   end

   // mode 0: random labels, 1: alternating 1,0,1..., 2: all ones
   task automatic run_batch(input int n, input int mode, input bit lat);
      logic [31:0] w;
      int lbl;
      @(posedge clk); #1;
      w = '0;
      exp_n = n; batch_rd = 0; vec_done = 0; done_pend = 1; done_seen = 0;
      for (int i = 0; i < n; i++) begin
         lbl = (mode == 1) ? ((i % 2) == 0) : (mode == 2) ? 1 : $urandom_range(1);
         lbl_q.push_back(lbl);
         w[i % 32] = lbl[0];
         if ((i % 32) == 31 || i == n - 1) begin
            exp_q.push_back(w);
            w = '0;
         end
      end
      bus.num_vecs = CNT_W'(n);
      bus.start    = 1'b1;
      start_cyc    = cyc;
      chk_lat      = lat;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("busy_after_start", bus.busy, 1);
   endtask

   task automatic wait_done(input int limit);
      int k = 0;
      while (!done_seen && k < limit) begin
         @(negedge clk);
         k++;
      end
      chk("done_seen", done_seen, 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      bus.start = 1'b0; bus.num_vecs = '0; bus.src_empty = 1'b1; bus.eng_rd = 1'b0;
      bus.eng_label = 1'b0; bus.eng_label_ready = 1'b0; bus.res_ready = 1'b0;
      #2 reset = 1'b1;
      #1 chk_reset("reset_values");
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("eng_rst_held", bus.eng_rst, 1);
      @(posedge clk); #1;
      chk("eng_rst_release", bus.eng_rst, 0);

      // single vector, label 1, with an ignored start while busy
      run_batch(1, 2, 0);
      repeat (50) @(posedge clk);
      #1 bus.num_vecs = CNT_W'(5); bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      chk("busy_hold", bus.busy, 1);
      wait_done(3000);

      // empty batch
      run_batch(0, 0, 1);
      wait_done(20);

      // starved FIFO with spurious label_ready blips
      starve = 1; spur = 1;
      run_batch(3, 0, 0);
      wait_done(10000);
      starve = 0; spur = 0;

      // 33 alternating labels, first word stalled for 100 cycles
      bp_left = 100;
      run_batch(33, 1, 0);
      wait_done(40000);
      chk("stall_applied", bp_left, 0);

      // abort at beat 200 of vector 3
      run_batch(5, 0, 0);
      for (int k = 0; k < 5000 && !(vec_done == 2 && eng_beats >= 200); k++) @(negedge clk);
      chk("abort_point", vec_done, 2);
      #2 reset = 1'b1;
      #1 chk_reset("abort_values");
      lbl_q.delete(); exp_q.delete();
      done_pend = 0; done_seen = 0; eng_beats = 0; lbl_up = 0; eng_clr = 0; held_v = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("no_done_after_abort", done_seen, 0);
      run_batch(2, 0, 0);
      wait_done(5000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
